// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry skid-buffered pipeline register with flush, bubble zeroing and stall/drop counters
module pipe_stage_reg #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 180,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [7:0]        drop_cnt
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t state;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic [DATA_W-1:0] main_data, skid_data;
    logic accept, fire;
    logic [1:0] held, dropped;
    logic [8:0] drop_sum;
    // reset also gates in_ready so nothing is offered a slot while the stage is held in reset
    assign in_ready  = state != FULL && !flush && !reset;
    assign out_valid = state != EMPTY;
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;
    assign held      = state == FULL ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
    assign dropped   = held - {1'b0, fire};
    assign drop_sum  = {1'b0, drop_cnt} + {7'b0, dropped};
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            stall_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush) begin
                state    <= EMPTY;
                drop_cnt <= drop_sum[8] ? 8'hff : drop_sum[7:0];
            end else begin
                case (state)
                    EMPTY: if (accept) begin
                        state     <= ONE;
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end
                    ONE: if (accept && fire) begin
                        main_ctrl <= in_ctrl;
                        main_data <= in_data;
                    end else if (accept) begin
                        state     <= FULL;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                    end else if (fire) begin
                        state <= EMPTY;
                    end
                    FULL: if (fire) begin
                        state     <= ONE;
                        main_ctrl <= skid_ctrl;
                        main_data <= skid_data;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: randomized and directed checks of pipe_stage_reg against a queue-based reference model
module tb_pipe_stage_reg;
    localparam int CW = 12;
    localparam int DW = 180;
    localparam int NW = 4;
    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;
    logic clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic in_ready, out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [NW-1:0] stall_cnt;
    logic [7:0] drop_cnt;
    ent_t q[$];
    ent_t last = '0;
    int m_stall = 0, m_drop = 0;
    int checks = 0, errors = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .CNT_W(NW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .stall_cnt(stall_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic ent_t rnd();
        logic [191:0] t;
        ent_t e;
        for (int i = 0; i < 6; i++) t[i*32 +: 32] = $urandom;
        e.c = CW'($urandom);
        e.d = t[DW-1:0];
        return e;
    endfunction

    // reference model: a FIFO of at most two entries, advanced once per clock edge
    task automatic tick();
        bit acc, f;
        acc = in_valid && q.size() < 2 && !flush && !reset;
        f = q.size() > 0 && out_ready;
        @(posedge clk);
        #1;
        if (reset) begin
            q.delete();
            last = '0;
            m_stall = 0;
            m_drop = 0;
        end else begin
            if (q.size() > 0 && !out_ready && m_stall < 15) m_stall++;
            if (f) void'(q.pop_front());
            if (flush) begin
                m_drop = (m_drop + q.size() > 255) ? 255 : m_drop + q.size();
                q.delete();
            end else if (acc) q.push_back({in_ctrl, in_data});
            if (q.size() > 0) last = q[0];
        end
    endtask

    task automatic test_reset();
        reset = 1; in_valid = 1; out_ready = 0; {in_ctrl, in_data} = rnd();
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_ctrl got %h want 0", out_ctrl); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", in_ready); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
        checks++; if (stall_cnt !== '0 || drop_cnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, drop_cnt); end
        reset = 0; in_valid = 0;
        tick();
    endtask

    task automatic test_streaming();
        ent_t e[8];
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            e[i] = rnd();
            {in_ctrl, in_data} = e[i]; in_valid = 1;
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got %b want 1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_ctrl !== e[i].c || out_data !== e[i].d)
                begin errors++; $display("FAIL stream_out[%0d] got v=%b c=%h want v=1 c=%h", i, out_valid, out_ctrl, e[i].c); end
            checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL stream_stall got %0d want 0", stall_cnt); end
        end
        in_valid = 0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        ent_t e[3];
        int k = 0;
        bit c_done = 0;
        for (int i = 0; i < 3; i++) e[i] = rnd();
        out_ready = 0;
        {in_ctrl, in_data} = e[0]; in_valid = 1; tick();
        {in_ctrl, in_data} = e[1]; tick();
        {in_ctrl, in_data} = e[2];
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready got %b want 0", in_ready); end
            tick();
            checks++; if (stall_cnt !== NW'(i + 2)) begin errors++; $display("FAIL bp_stall got %0d want %0d", stall_cnt, i + 2); end
        end
        out_ready = 1;
        for (int n = 0; n < 10 && k < 3; n++) begin
            in_valid = !c_done;
            #1;
            if (out_valid) begin
                checks++; if ({out_ctrl, out_data} !== e[k]) begin errors++; $display("FAIL bp_order[%0d] got c=%h want c=%h", k, out_ctrl, e[k].c); end
                k++;
            end
            if (in_valid && in_ready) c_done = 1;
            tick();
        end
        in_valid = 0;
        checks++; if (k !== 3) begin errors++; $display("FAIL bp_count got %0d want 3", k); end
        tick();
    endtask

    task automatic test_flush_full();
        ent_t a, b;
        int exp_drop;
        a = rnd(); b = rnd();
        out_ready = 0;
        {in_ctrl, in_data} = a; in_valid = 1; tick();
        {in_ctrl, in_data} = b; tick();
        exp_drop = (m_drop + 2 > 255) ? 255 : m_drop + 2;
        {in_ctrl, in_data} = rnd(); flush = 1;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
        tick();
        flush = 0; in_valid = 0;
        checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin errors++; $display("FAIL flush_full_out got v=%b c=%h want 0/0", out_valid, out_ctrl); end
        checks++; if (drop_cnt !== 8'(exp_drop)) begin errors++; $display("FAIL flush_full_drop got %0d want %0d", drop_cnt, exp_drop); end
        checks++; if (out_data !== a.d) begin errors++; $display("FAIL flush_retain got %h want %h", out_data, a.d); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_accept got %b want 0", out_valid); end
    endtask

    task automatic test_flush_one();
        int d0;
        out_ready = 0;
        {in_ctrl, in_data} = rnd(); in_valid = 1; tick();
        in_valid = 0; out_ready = 1; flush = 1; d0 = m_drop;
        tick();
        flush = 0;
        checks++; if (drop_cnt !== 8'(d0) || out_valid !== 1'b0) begin errors++; $display("FAIL flush_one got drop=%0d v=%b want drop=%0d v=0", drop_cnt, out_valid, d0); end
    endtask

    task automatic test_saturation();
        ent_t a;
        a = rnd();
        out_ready = 0;
        {in_ctrl, in_data} = a; in_valid = 1; tick();
        in_valid = 0;
        repeat (20) tick();
        checks++; if (stall_cnt !== 4'hf) begin errors++; $display("FAIL stall_sat got %0d want 15", stall_cnt); end
        checks++; if (out_valid !== 1'b1 || out_data !== a.d) begin errors++; $display("FAIL stall_hold got v=%b want 1", out_valid); end
        out_ready = 1; tick();
    endtask

    task automatic test_reset_midstream();
        ent_t e;
        out_ready = 0;
        {in_ctrl, in_data} = rnd(); in_valid = 1; tick();
        {in_ctrl, in_data} = rnd(); tick();
        reset = 1; in_valid = 0; tick();
        reset = 0;
        checks++; if (out_valid !== 1'b0 || out_data !== '0) begin errors++; $display("FAIL rst_mid_out got v=%b d=%h want 0/0", out_valid, out_data); end
        checks++; if (drop_cnt !== '0 || stall_cnt !== '0) begin errors++; $display("FAIL rst_mid_cnt got %0d/%0d want 0/0", drop_cnt, stall_cnt); end
        e = rnd();
        {in_ctrl, in_data} = e; in_valid = 1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        checks++; if (out_valid !== 1'b1 || out_data !== e.d) begin errors++; $display("FAIL rst_mid_accept got v=%b want 1", out_valid); end
    endtask

    task automatic test_drop_sat();
        out_ready = 0;
        repeat (130) begin
            {in_ctrl, in_data} = rnd(); in_valid = 1; tick();
            {in_ctrl, in_data} = rnd(); tick();
            in_valid = 0; flush = 1; tick();
            flush = 0;
        end
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d want 255", drop_cnt); end
    endtask

    task automatic test_random();
        repeat (400) begin
            in_valid = $urandom % 4 != 0;
            out_ready = $urandom % 3 != 0;
            flush = $urandom % 12 == 0;
            reset = $urandom % 50 == 0;
            {in_ctrl, in_data} = rnd();
            #1;
            checks++; if (in_ready !== (q.size() < 2 && !flush && !reset)) begin errors++; $display("FAIL rnd_ready got %b", in_ready); end
            tick();
            checks++; if (out_valid !== (q.size() > 0)) begin errors++; $display("FAIL rnd_valid got %b want %b", out_valid, q.size() > 0); end
            checks++; if (out_ctrl !== (q.size() > 0 ? q[0].c : CW'(0))) begin errors++; $display("FAIL rnd_ctrl got %h", out_ctrl); end
            checks++; if (out_data !== last.d) begin errors++; $display("FAIL rnd_data got %h want %h", out_data, last.d); end
            checks++; if (stall_cnt !== NW'(m_stall) || drop_cnt !== 8'(m_drop))
                begin errors++; $display("FAIL rnd_cnt got %0d/%0d want %0d/%0d", stall_cnt, drop_cnt, m_stall, m_drop); end
        end
        reset = 0; flush = 0; in_valid = 0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_flush_one();
        test_saturation();
        test_reset_midstream();
        test_drop_sat();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
